// File: rtl/seq_unsigned_divider.sv
// -----------------------------------------------------------------------------
// seq_unsigned_divider
//
// Iterative restoring divider, the inverse of the product_gen unsigned
// multiplier. A 2*WORD_SIZE-bit dividend is divided by a WORD_SIZE-bit
// divisor, producing one quotient bit per clock. Valid/ready handshakes on
// both the operand and the result side.
//
// State table:
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   S_IDLE | waiting for operands, in_ready=1, previous results still shown
//   S_CALC | one restoring step per clock, WORD_SIZE steps total
//   S_DONE | result/flags valid and held until out_ready
//
// Ports:
//   clk        in   1            clock, all state on posedge
//   rst_n      in   1            asynchronous active-low reset
//   in_valid   in   1            dividend/divisor present
//   in_ready   out  1            high only in S_IDLE
//   dividend   in   2*WORD_SIZE  unsigned dividend, sampled on accept edge
//   divisor    in   WORD_SIZE    unsigned divisor, sampled on accept edge
//   out_valid  out  1            result valid, held until taken
//   out_ready  in   1            consumer takes result
//   quotient   out  WORD_SIZE    unsigned quotient (all ones on error)
//   remainder  out  WORD_SIZE    unsigned remainder (zero on error)
//   div_zero   out  1            divisor was zero
//   overflow   out  1            quotient would not fit in WORD_SIZE bits
// -----------------------------------------------------------------------------
module seq_unsigned_divider #(
  parameter int WORD_SIZE = 29
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*WORD_SIZE-1:0]   dividend,
  input  logic [WORD_SIZE-1:0]     divisor,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_SIZE-1:0]     quotient,
  output logic [WORD_SIZE-1:0]     remainder,
  output logic                     div_zero,
  output logic                     overflow
);

  localparam int W  = WORD_SIZE;
  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Working registers. r_rem holds the partial remainder; its extra (W+1)th
  // bit is never needed in storage because the remainder stays below the
  // divisor between steps. r_lo starts as the dividend low half and, as its
  // bits are consumed MSB-first, quotient bits fill in from the LSB, so after
  // the last step it holds the quotient.
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_div;
  logic [CW-1:0] r_cnt;

  logic [W-1:0]  r_quotient;
  logic [W-1:0]  r_remainder;
  logic          r_div_zero;
  logic          r_overflow;

  logic          w_accept;
  logic          w_dz;
  logic          w_ov;
  logic          w_err;
  logic          w_last;
  logic [W:0]    w_t;
  logic          w_ge;
  logic [W-1:0]  w_r_next;
  logic [W-1:0]  w_q_next;

  assign w_accept = in_valid && (r_state == S_IDLE);

  // Zero divisor takes priority; overflow when the high half alone already
  // reaches the divisor, i.e. the quotient needs more than W bits.
  assign w_dz  = (divisor == '0);
  assign w_ov  = !w_dz && (dividend[2*W-1:W] >= divisor);
  assign w_err = w_dz || w_ov;

  assign w_last = (r_cnt == CW'(W - 1));

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  assign w_t      = {r_rem, r_lo[W-1]};
  assign w_ge     = (w_t >= {1'b0, r_div});
  assign w_r_next = w_ge ? W'(w_t - {1'b0, r_div}) : w_t[W-1:0];
  assign w_q_next = {r_lo[W-2:0], w_ge};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = w_err ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem       <= '0;
      r_lo        <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_accept) begin
      r_rem      <= dividend[2*W-1:W];
      r_lo       <= dividend[W-1:0];
      r_div      <= divisor;
      r_cnt      <= '0;
      r_div_zero <= w_dz;
      r_overflow <= w_ov;
      if (w_err) begin
        r_quotient  <= '1;
        r_remainder <= '0;
      end
    end else if (r_state == S_CALC) begin
      r_rem <= w_r_next;
      r_lo  <= w_q_next;
      r_cnt <= r_cnt + CW'(1);
      // Results are only published on the final step so the outputs never
      // show a half-built quotient.
      if (w_last) begin
        r_quotient  <= w_q_next;
        r_remainder <= w_r_next;
      end
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_seq_unsigned_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_unsigned_divider
//
// Runs two divider instances (WORD_SIZE=29 and WORD_SIZE=8) off one clock and
// reset. Expected results come from a behavioural reference model, are pushed
// to a scoreboard when operands are driven and popped when the DUT presents
// its result.
// -----------------------------------------------------------------------------
module tb_seq_unsigned_divider;

  logic clk;
  logic rst_n;

  logic        in_valid29, in_ready29, out_valid29, out_ready29;
  logic [57:0] dividend29;
  logic [28:0] divisor29, quotient29, remainder29;
  logic        div_zero29, overflow29;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [15:0] dividend8;
  logic [7:0]  divisor8, quotient8, remainder8;
  logic        div_zero8, overflow8;

  seq_unsigned_divider #(.WORD_SIZE(29)) u_dut29 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid29),
    .in_ready  (in_ready29),
    .dividend  (dividend29),
    .divisor   (divisor29),
    .out_valid (out_valid29),
    .out_ready (out_ready29),
    .quotient  (quotient29),
    .remainder (remainder29),
    .div_zero  (div_zero29),
    .overflow  (overflow29)
  );

  seq_unsigned_divider #(.WORD_SIZE(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .dividend  (dividend8),
    .divisor   (divisor8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .quotient  (quotient8),
    .remainder (remainder8),
    .div_zero  (div_zero8),
    .overflow  (overflow8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [63:0] dvd, input logic [63:0] dvs, input int w);
    exp_t e;
    logic [63:0] ones;
    ones = (64'd1 << w) - 64'd1;
    e.dz = (dvs == 64'd0);
    e.ov = 1'b0;
    if (e.dz) begin
      e.q = ones;
      e.r = 64'd0;
    end else if ((dvd >> w) >= dvs) begin
      e.ov = 1'b1;
      e.q  = ones;
      e.r  = 64'd0;
    end else begin
      e.q = dvd / dvs;
      e.r = dvd % dvs;
    end
    return e;
  endfunction

  function automatic logic f_out_valid(input bit sel);
    return sel ? out_valid29 : out_valid8;
  endfunction
  function automatic logic f_in_ready(input bit sel);
    return sel ? in_ready29 : in_ready8;
  endfunction
  function automatic logic [63:0] f_q(input bit sel);
    return sel ? 64'(quotient29) : 64'(quotient8);
  endfunction
  function automatic logic [63:0] f_r(input bit sel);
    return sel ? 64'(remainder29) : 64'(remainder8);
  endfunction
  function automatic logic f_dz(input bit sel);
    return sel ? div_zero29 : div_zero8;
  endfunction
  function automatic logic f_ov(input bit sel);
    return sel ? overflow29 : overflow8;
  endfunction

  task automatic drive_in(input bit sel, input logic v, input logic [63:0] dvd, input logic [63:0] dvs);
    if (sel) begin
      in_valid29 = v;
      dividend29 = dvd[57:0];
      divisor29  = dvs[28:0];
    end else begin
      in_valid8  = v;
      dividend8  = dvd[15:0];
      divisor8   = dvs[7:0];
    end
  endtask

  task automatic set_ordy(input bit sel, input logic v);
    if (sel) out_ready29 = v;
    else     out_ready8  = v;
  endtask

  // One complete transaction: drive, measure latency, optionally hold the
  // result under backpressure, check it against the scoreboard, release.
  // Latency counts posedges after the accept edge; error results are already
  // visible right after the accept edge itself.
  task automatic run_op(input bit sel, input logic [63:0] dvd, input logic [63:0] dvs, input int hold);
    exp_t e;
    exp_t s;
    int   n;
    int   w;
    w = sel ? 29 : 8;
    e = model(dvd, dvs, w);
    sb.push_back(e);
    @(negedge clk);
    drive_in(sel, 1'b1, dvd, dvs);
    chk("in_ready_idle", 64'(f_in_ready(sel)), 64'd1);
    @(posedge clk);
    @(negedge clk);
    drive_in(sel, 1'b0, 64'd0, 64'd0);
    n = 0;
    while (!f_out_valid(sel) && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), (e.dz || e.ov) ? 64'd0 : 64'(w));
    if (n >= 64) begin
      void'(sb.pop_front());
      return;
    end
    s = sb.pop_front();
    set_ordy(sel, 1'b0);
    for (int i = 0; i < hold; i++) begin
      drive_in(sel, (i % 2) == 0, 64'($urandom), 64'($urandom));
      @(negedge clk);
      chk("hold_out_valid", 64'(f_out_valid(sel)), 64'd1);
      chk("hold_in_ready", 64'(f_in_ready(sel)), 64'd0);
      chk("hold_quotient", f_q(sel), s.q);
      chk("hold_remainder", f_r(sel), s.r);
      chk("hold_flags", {62'd0, f_dz(sel), f_ov(sel)}, {62'd0, s.dz, s.ov});
    end
    drive_in(sel, 1'b0, 64'd0, 64'd0);
    chk("quotient", f_q(sel), s.q);
    chk("remainder", f_r(sel), s.r);
    chk("div_zero", 64'(f_dz(sel)), 64'(s.dz));
    chk("overflow", 64'(f_ov(sel)), 64'(s.ov));
    if (!s.dz && !s.ov) begin
      chk("invariant", f_q(sel) * dvs + f_r(sel), dvd);
      chk("rem_lt_div", 64'(f_r(sel) < dvs), 64'd1);
    end
    set_ordy(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ordy(sel, 1'b0);
    chk("idle_out_valid", 64'(f_out_valid(sel)), 64'd0);
    chk("idle_in_ready", 64'(f_in_ready(sel)), 64'd1);
    chk("idle_quotient_kept", f_q(sel), s.q);
    if (hold > 0) begin
      @(negedge clk);
      chk("no_queued_op", 64'(f_out_valid(sel)), 64'd0);
      chk("no_queued_ready", 64'(f_in_ready(sel)), 64'd1);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid8"}, 64'(out_valid8), 64'd0);
    chk({tag, "_in_ready8"}, 64'(in_ready8), 64'd1);
    chk({tag, "_quotient8"}, 64'(quotient8), 64'd0);
    chk({tag, "_remainder8"}, 64'(remainder8), 64'd0);
    chk({tag, "_flags8"}, {62'd0, div_zero8, overflow8}, 64'd0);
    chk({tag, "_out_valid29"}, 64'(out_valid29), 64'd0);
    chk({tag, "_in_ready29"}, 64'(in_ready29), 64'd1);
    chk({tag, "_quotient29"}, 64'(quotient29), 64'd0);
    chk({tag, "_remainder29"}, 64'(remainder29), 64'd0);
    chk({tag, "_flags29"}, {62'd0, div_zero29, overflow29}, 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d compared expected completion", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    logic [63:0] big;

    rst_n = 1'b0;
    drive_in(1'b1, 1'b0, 64'd0, 64'd0);
    drive_in(1'b0, 1'b0, 64'd0, 64'd0);
    out_ready29 = 1'b0;
    out_ready8  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b1, 64'd42, 64'd7, 0);
    big = ((64'd1 << 29) - 64'd1) * ((64'd1 << 29) - 64'd1) + ((64'd1 << 29) - 64'd2);
    run_op(1'b1, big, (64'd1 << 29) - 64'd1, 2);

    run_op(1'b0, 64'h1234, 64'd0, 0);
    run_op(1'b0, 64'h0500, 64'd5, 0);
    run_op(1'b0, 64'h04FF, 64'd5, 10);

    // Reset in the middle of a calculation: three CALC steps completed.
    @(negedge clk);
    drive_in(1'b0, 1'b1, 64'd200, 64'd3);
    @(posedge clk);
    @(negedge clk);
    drive_in(1'b0, 1'b0, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midcalc_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 64'd100, 64'd9, 0);

    for (int k = 0; k < 2000; k++) begin
      ra = 16'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 31) == 0) rb = 8'd0;
      if (rb != 8'd0 && $urandom_range(0, 3) != 0) ra[15:8] = 8'($urandom_range(0, int'(rb) - 1));
      run_op(1'b0, 64'(ra), 64'(rb), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
